// File: rtl/panel_pkg.sv
// Shared definitions for the front-panel button conditioner.
//   - Button index constants (bit positions within btn_raw / held).
//   - Repeat FSM state encoding.
//   - Issue priority order and a helper that picks the winning pending bit.
package panel_pkg;

    localparam int NUM_BTN   = 4;

    localparam int BTN_LEFT  = 0;
    localparam int BTN_RIGHT = 1;
    localparam int BTN_UP    = 2;
    localparam int BTN_DOWN  = 3;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DELAY  = 2'd1,
        REPEAT = 2'd2
    } rpt_state_t;

    // Two-bit button indices packed by priority slot; slot 0 (LSBs) wins.
    // Order is right > left > up > down, matching the downstream panel chain.
    localparam logic [2*NUM_BTN-1:0] PRIO_ORDER = {2'd3, 2'd2, 2'd0, 2'd1};

    // One-hot grant of the highest-priority set bit of pend (zero if none).
    // Walks from the lowest-priority slot upward so the best match overwrites.
    function automatic logic [NUM_BTN-1:0] prio_pick(input logic [NUM_BTN-1:0] pend);
        logic [NUM_BTN-1:0] grant;
        logic [1:0]         idx;
        grant = '0;
        for (int p = NUM_BTN - 1; p >= 0; p--) begin
            idx = PRIO_ORDER[2*p +: 2];
            if (pend[idx]) begin
                grant = NUM_BTN'(1) << idx;
            end
        end
        return grant;
    endfunction

endpackage

// File: rtl/button_debounce.sv
// Synchroniser plus debounce filter for a single raw button bit.
// Ports:
//   clk      - system clock, rising edge
//   reset_n  - asynchronous active-low reset
//   i_raw    - raw, unsynchronised button level
//   o_held   - debounced level; changes only after DEBOUNCE_CYCLES
//              consecutive cycles of disagreement with the synchronised input
module button_debounce #(
    parameter int DEBOUNCE_CYCLES = 250000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic i_raw,
    output logic o_held
);

    localparam int             CW       = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0]  CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          r_sync1;
    logic          r_sync2;
    logic          r_held;
    logic [CW-1:0] r_cnt;

    // The counter value counts disagreeing cycles already seen; the edge that
    // would take it to DEBOUNCE_CYCLES toggles the level instead.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_held  <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_sync1 <= i_raw;
            r_sync2 <= r_sync1;
            if (r_sync2 == r_held) begin
                r_cnt <= '0;
            end else if (r_cnt >= CNT_LAST) begin
                r_held <= ~r_held;
                r_cnt  <= '0;
            end else begin
                r_cnt <= r_cnt + CW'(1);
            end
        end
    end

    assign o_held = r_held;

endmodule

// File: rtl/panel_buttons.sv
// Front-panel navigation button conditioner.
// Each raw button is synchronised and debounced, a per-button repeat FSM
// raises requests on press and while held, and a priority arbiter issues at
// most one single-cycle command pulse per clock.
// Ports:
//   clk                 - system clock, rising edge
//   reset_n             - asynchronous active-low reset
//   btn_raw[3:0]        - raw buttons, bit 0 left, 1 right, 2 up, 3 down
//   left/right/up/down  - one-cycle command pulses, mutually exclusive
//   held[3:0]           - debounced button levels, same bit order as btn_raw
module panel_buttons
    import panel_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int REPEAT_DELAY    = 12500000,
    parameter int REPEAT_RATE     = 2500000
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [NUM_BTN-1:0]  btn_raw,
    output logic                left,
    output logic                right,
    output logic                up,
    output logic                down,
    output logic [NUM_BTN-1:0]  held
);

    localparam int            TMAX    = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int            TW      = $clog2(TMAX + 1);
    localparam logic [TW-1:0] T_DELAY = TW'(REPEAT_DELAY);
    localparam logic [TW-1:0] T_RATE  = TW'(REPEAT_RATE);

    logic [NUM_BTN-1:0] w_held;
    logic [NUM_BTN-1:0] w_req;
    logic [NUM_BTN-1:0] w_issue;
    logic [NUM_BTN-1:0] w_pending_next;
    logic [NUM_BTN-1:0] r_pending;
    logic [NUM_BTN-1:0] r_pulse;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_BTN; gi++) begin : g_btn
            rpt_state_t    r_state;
            rpt_state_t    w_state_next;
            logic [TW-1:0] r_timer;
            logic [TW-1:0] w_timer_next;
            logic          w_req_bit;

            button_debounce #(
                .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
            ) u_debounce (
                .clk     (clk),
                .reset_n (reset_n),
                .i_raw   (btn_raw[gi]),
                .o_held  (w_held[gi])
            );

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    r_state <= IDLE;
                    r_timer <= '0;
                end else begin
                    r_state <= w_state_next;
                    r_timer <= w_timer_next;
                end
            end

            // Any fall of the held level sends the FSM home, so seeing the
            // level high while in IDLE is always a fresh press.
            // Timer holds cycles remaining until the next request; it fires
            // on the edge where it would reach zero and reloads immediately,
            // so contention at the arbiter never shifts the repeat schedule.
            always_comb begin
                w_state_next = r_state;
                w_timer_next = r_timer;
                w_req_bit    = 1'b0;
                if (!w_held[gi]) begin
                    w_state_next = IDLE;
                    w_timer_next = '0;
                end else begin
                    case (r_state)
                        IDLE: begin
                            w_req_bit    = 1'b1;
                            w_timer_next = T_DELAY;
                            w_state_next = DELAY;
                        end
                        DELAY, REPEAT: begin
                            if (r_timer <= TW'(1)) begin
                                w_req_bit    = 1'b1;
                                w_timer_next = T_RATE;
                                w_state_next = REPEAT;
                            end else begin
                                w_timer_next = r_timer - TW'(1);
                            end
                        end
                        default: begin
                            w_state_next = IDLE;
                            w_timer_next = '0;
                        end
                    endcase
                end
            end

            assign w_req[gi] = w_req_bit;
        end
    endgenerate

    // A new request for the bit being issued this cycle re-arms it, and a
    // request for an already pending bit merges into the existing one.
    always_comb begin
        w_issue        = prio_pick(r_pending);
        w_pending_next = (r_pending & ~w_issue) | w_req;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pending <= '0;
            r_pulse   <= '0;
        end else begin
            r_pending <= w_pending_next;
            r_pulse   <= w_issue;
        end
    end

    assign left  = r_pulse[BTN_LEFT];
    assign right = r_pulse[BTN_RIGHT];
    assign up    = r_pulse[BTN_UP];
    assign down  = r_pulse[BTN_DOWN];
    assign held  = w_held;

endmodule

// File: tb/tb_panel_buttons.sv
module tb_panel_buttons;

    localparam int D  = 4;
    localparam int RD = 20;
    localparam int RR = 8;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [3:0] btn_raw;
    logic       left, right, up, down;
    logic [3:0] held;

    panel_buttons #(
        .DEBOUNCE_CYCLES (D),
        .REPEAT_DELAY    (RD),
        .REPEAT_RATE     (RR)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .btn_raw (btn_raw),
        .left    (left),
        .right   (right),
        .up      (up),
        .down    (down),
        .held    (held)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int edge_n = 0;

    // Reference model state
    logic [3:0] m_s1, m_s2, m_held, m_pend, m_out;
    int         m_run  [4];
    int         m_rise [4];

    // Observed pulse log for the current scenario
    int dut_cnt [4];
    int q_edge  [$];
    int q_idx   [$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s edge=%0d got=%0h expected=%0h", tag, edge_n, obs, exp);
        end
    endtask

    function automatic logic [3:0] highest(input logic [3:0] p);
        int order [4];
        order = '{1, 0, 2, 3};
        for (int k = 0; k < 4; k++) begin
            if (p[order[k]]) return 4'(1) << order[k];
        end
        return 4'b0;
    endfunction

    task automatic model_reset();
        m_s1 = '0; m_s2 = '0; m_held = '0; m_pend = '0; m_out = '0;
        for (int i = 0; i < 4; i++) begin
            m_run[i]  = 0;
            m_rise[i] = -1;
        end
    endtask

    // Requests follow a schedule anchored at the edge where held rose:
    // one edge after the rise, then RD later, then every RR while still held.
    task automatic model_edge(input logic [3:0] raw);
        logic [3:0] req;
        logic [3:0] iss;
        int         d;
        edge_n++;
        req = '0;
        for (int i = 0; i < 4; i++) begin
            if (m_held[i] && m_rise[i] >= 0) begin
                d = edge_n - m_rise[i] - 1;
                if (d == 0 || (d >= RD && (d - RD) % RR == 0)) req[i] = 1'b1;
            end
        end
        iss    = highest(m_pend);
        m_out  = iss;
        m_pend = (m_pend & ~iss) | req;
        for (int i = 0; i < 4; i++) begin
            if (m_s2[i] != m_held[i]) begin
                m_run[i]++;
                if (m_run[i] == D) begin
                    m_held[i] = ~m_held[i];
                    m_run[i]  = 0;
                    if (m_held[i]) m_rise[i] = edge_n;
                end
            end else begin
                m_run[i] = 0;
            end
        end
        m_s2 = m_s1;
        m_s1 = raw;
    endtask

    task automatic clear_log();
        for (int i = 0; i < 4; i++) dut_cnt[i] = 0;
        q_edge.delete();
        q_idx.delete();
    endtask

    // Entered at a falling edge; drives raw, advances one rising edge, checks.
    task automatic step(input logic [3:0] raw);
        logic [3:0] pulses;
        btn_raw = raw;
        @(posedge clk);
        #1;
        model_edge(raw);
        pulses = {down, up, right, left};
        check("held",   32'(held),   32'(m_held));
        check("pulse",  32'(pulses), 32'(m_out));
        check("onehot", 32'($countones(pulses) <= 1), 32'(1));
        for (int i = 0; i < 4; i++) begin
            if (pulses[i]) begin
                dut_cnt[i]++;
                q_edge.push_back(edge_n);
                q_idx.push_back(i);
            end
        end
        @(negedge clk);
    endtask

    initial begin
        int start_edge;
        int lvl [4];
        int rem [4];
        logic [3:0] r;

        reset_n = 1'b0;
        btn_raw = 4'b0;
        model_reset();
        repeat (3) @(negedge clk);
        check("rst_held",  32'(held), 32'(0));
        check("rst_pulse", 32'({down, up, right, left}), 32'(0));
        reset_n = 1'b1;

        // Clean press and release of left
        clear_log();
        repeat (10) step(4'b0000);
        start_edge = edge_n + 1;
        repeat (20) step(4'b0001);
        repeat (25) step(4'b0000);
        check("press_left_count", 32'(dut_cnt[0]), 32'(1));
        if (q_edge.size() > 0)
            check("press_latency", 32'(q_edge[0] - start_edge), 32'(D + 3));
        else
            check("press_latency", 32'(-1), 32'(D + 3));

        // Bounce on right, shorter than the debounce window
        clear_log();
        for (int c = 0; c < 40; c++) step(((c / 2) % 2) != 0 ? 4'b0010 : 4'b0000);
        repeat (15) step(4'b0000);
        check("bounce_right_count", 32'(dut_cnt[1]), 32'(0));
        check("bounce_held",        32'(held),       32'(0));

        // Auto-repeat on up
        clear_log();
        repeat (60) step(4'b0100);
        repeat (20) step(4'b0000);
        check("repeat_up_count", 32'(dut_cnt[2]), 32'(6));
        if (q_edge.size() == 6) begin
            check("repeat_gap_first", 32'(q_edge[1] - q_edge[0]), 32'(RD));
            for (int k = 2; k < 6; k++)
                check("repeat_gap_rate", 32'(q_edge[k] - q_edge[k-1]), 32'(RR));
        end

        // Simultaneous press of all four
        clear_log();
        repeat (15) step(4'b1111);
        repeat (15) step(4'b0000);
        if (q_idx.size() == 4) begin
            check("simul_order0", 32'(q_idx[0]), 32'(1));
            check("simul_order1", 32'(q_idx[1]), 32'(0));
            check("simul_order2", 32'(q_idx[2]), 32'(2));
            check("simul_order3", 32'(q_idx[3]), 32'(3));
            check("simul_consecutive", 32'(q_edge[3] - q_edge[0]), 32'(3));
        end else begin
            check("simul_pulse_count", 32'(q_idx.size()), 32'(4));
        end

        // Reset in the middle of auto-repeat, button still held
        repeat (40) step(4'b0100);
        #2;
        reset_n = 1'b0;
        #1;
        check("midrst_pulse", 32'({down, up, right, left}), 32'(0));
        check("midrst_held",  32'(held), 32'(0));
        model_reset();
        @(negedge clk);
        reset_n = 1'b1;
        clear_log();
        start_edge = edge_n + 1;
        repeat (15) step(4'b0100);
        if (q_edge.size() > 0)
            check("midrst_redebounce", 32'(q_edge[0] - start_edge), 32'(D + 3));
        else
            check("midrst_redebounce", 32'(-1), 32'(D + 3));
        repeat (20) step(4'b0000);

        // Randomised hold/release segments with occasional single-cycle glitches
        for (int i = 0; i < 4; i++) begin
            lvl[i] = 0;
            rem[i] = 0;
        end
        for (int c = 0; c < 2500; c++) begin
            for (int i = 0; i < 4; i++) begin
                if (rem[i] == 0) begin
                    lvl[i] = int'($urandom_range(0, 1));
                    rem[i] = int'($urandom_range(1, 60));
                end
                rem[i]--;
                r[i] = (lvl[i] != 0) ^ ($urandom_range(0, 15) == 0);
            end
            step(r);
        end
        repeat (20) step(4'b0000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
